// File: rtl/datamem_arbiter.sv
// Round-robin arbiter mapping N PE data-memory requests onto NB_PORTS memory ports.
// Define DATAMEM_ARB_PERF_EN to add the saturating stall-cycle counter output stall_cnt_o.
module datamem_arbiter #(
    parameter int unsigned NB_ROWS  = 4,
    parameter int unsigned NB_COLS  = 4,
    parameter int unsigned NB_PORTS = 2,
    parameter int unsigned ADDR_W   = 12
) (
    input  logic                                      clk,
    input  logic                                      rst,
    input  logic [NB_ROWS*NB_COLS-1:0]                req_i,
    input  logic [NB_ROWS*NB_COLS-1:0]                we_i,
    input  logic [NB_ROWS*NB_COLS-1:0][ADDR_W-1:0]    addr_i,
    input  logic [NB_ROWS*NB_COLS-1:0][31:0]          wdata_i,
    output logic [NB_ROWS*NB_COLS-1:0]                gnt_o,
    output logic [NB_ROWS*NB_COLS-1:0]                rvalid_o,
    output logic [NB_ROWS*NB_COLS-1:0][31:0]          rdata_o,
    output logic [NB_PORTS-1:0]                       mem_req_o,
    output logic [NB_PORTS-1:0]                       mem_we_o,
    output logic [NB_PORTS-1:0][ADDR_W-1:0]           mem_addr_o,
    output logic [NB_PORTS-1:0][31:0]                 mem_wdata_o,
    input  logic [NB_PORTS-1:0][31:0]                 mem_rdata_i,
    output logic                                      stall_o
`ifdef DATAMEM_ARB_PERF_EN
    ,
    output logic [31:0]                               stall_cnt_o
`endif
);

    localparam int unsigned N     = NB_ROWS * NB_COLS;
    localparam int unsigned IDX_W = (N > 1) ? $clog2(N) : 1;

    logic [IDX_W-1:0]                rr_ptr_q, rr_ptr_d;
    logic [NB_PORTS-1:0]             pv_q;
    logic [NB_PORTS-1:0]             pread_q;
    logic [NB_PORTS-1:0][IDX_W-1:0]  pidx_q;
    logic [NB_PORTS-1:0][IDX_W-1:0]  port_idx;

    // Grant scan: walk from rr_ptr, fill ports in order, defer same-address second writers.
    always_comb begin : arb_comb
        int         cnt;
        int         idx;
        int         nxt;
        logic       conflict;
        logic [IDX_W-1:0] sel;
        gnt_o       = '0;
        mem_req_o   = '0;
        mem_we_o    = '0;
        mem_addr_o  = '0;
        mem_wdata_o = '0;
        port_idx    = '0;
        rr_ptr_d    = rr_ptr_q;
        cnt         = 0;
        idx         = 0;
        nxt         = 0;
        conflict    = 1'b0;
        sel         = '0;
        for (int j = 0; j < int'(N); j++) begin
            idx = int'(rr_ptr_q) + j;
            if (idx >= int'(N)) idx = idx - int'(N);
            sel = IDX_W'(idx);
            conflict = 1'b0;
            for (int k = 0; k < int'(NB_PORTS); k++) begin
                if (k < cnt && mem_we_o[k] && we_i[sel] && mem_addr_o[k] == addr_i[sel])
                    conflict = 1'b1;
            end
            if (!rst && req_i[sel] && cnt < int'(NB_PORTS) && !conflict) begin
                gnt_o[sel] = 1'b1;
                for (int k = 0; k < int'(NB_PORTS); k++) begin
                    if (k == cnt) begin
                        mem_req_o[k]   = 1'b1;
                        mem_we_o[k]    = we_i[sel];
                        mem_addr_o[k]  = addr_i[sel];
                        mem_wdata_o[k] = wdata_i[sel];
                        port_idx[k]    = sel;
                    end
                end
                cnt = cnt + 1;
                nxt = idx + 1;
                rr_ptr_d = (nxt >= int'(N)) ? '0 : IDX_W'(nxt);
            end
        end
    end

    assign stall_o = !rst && (|(req_i & ~gnt_o));

    // Per-port return pipeline: remembers which PE owns next cycle's read data.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            rr_ptr_q <= '0;
            pv_q     <= '0;
            pread_q  <= '0;
            pidx_q   <= '0;
        end else begin
            rr_ptr_q <= rr_ptr_d;
            pv_q     <= mem_req_o;
            pread_q  <= ~mem_we_o;
            pidx_q   <= port_idx;
        end
    end

    always_comb begin
        rvalid_o = '0;
        rdata_o  = '0;
        for (int k = 0; k < int'(NB_PORTS); k++) begin
            if (pv_q[k] && pread_q[k]) begin
                rvalid_o[pidx_q[k]] = 1'b1;
                rdata_o[pidx_q[k]]  = mem_rdata_i[k];
            end
        end
    end

`ifdef DATAMEM_ARB_PERF_EN
    logic [31:0] stall_cnt_q;

    always_ff @(posedge clk or posedge rst) begin
        if (rst)
            stall_cnt_q <= '0;
        else if (stall_o && stall_cnt_q != 32'hFFFF_FFFF)
            stall_cnt_q <= stall_cnt_q + 32'd1;
    end

    assign stall_cnt_o = stall_cnt_q;
`endif

endmodule

// File: tb/tb_datamem_arbiter.sv
// Self-checking bench for datamem_arbiter (N=16, 2 ports): vector table, directed corners, random vs model.
module tb_datamem_arbiter;

    localparam int N  = 16;
    localparam int P  = 2;
    localparam int AW = 12;

    logic                   clk = 1'b0;
    logic                   rst = 1'b1;
    logic [N-1:0]           req = '0;
    logic [N-1:0]           we = '0;
    logic [N-1:0][AW-1:0]   addr = '0;
    logic [N-1:0][31:0]     wdata = '0;
    logic [N-1:0]           gnt;
    logic [N-1:0]           rvalid;
    logic [N-1:0][31:0]     rdata;
    logic [P-1:0]           mem_req;
    logic [P-1:0]           mem_we;
    logic [P-1:0][AW-1:0]   mem_addr;
    logic [P-1:0][31:0]     mem_wdata;
    logic [P-1:0][31:0]     rd_q = '0;
    logic                   stall;
`ifdef DATAMEM_ARB_PERF_EN
    logic [31:0]            stall_cnt;
`endif

    int n_chk = 0;
    int n_fail = 0;

    always #5 clk = ~clk;

    datamem_arbiter #(.NB_ROWS(4), .NB_COLS(4), .NB_PORTS(P), .ADDR_W(AW)) dut (
        .clk(clk), .rst(rst),
        .req_i(req), .we_i(we), .addr_i(addr), .wdata_i(wdata),
        .gnt_o(gnt), .rvalid_o(rvalid), .rdata_o(rdata),
        .mem_req_o(mem_req), .mem_we_o(mem_we), .mem_addr_o(mem_addr),
        .mem_wdata_o(mem_wdata), .mem_rdata_i(rd_q),
        .stall_o(stall)
`ifdef DATAMEM_ARB_PERF_EN
        , .stall_cnt_o(stall_cnt)
`endif
    );

    // Memory environment: one-cycle read latency, reads see pre-write contents.
    logic [31:0] env_mem [0:(1<<AW)-1];
    always @(posedge clk) begin
        for (int k = 0; k < P; k++) begin
            if (mem_req[k]) begin
                if (mem_we[k]) env_mem[mem_addr[k]] <= mem_wdata[k];
                else           rd_q[k] <= env_mem[mem_addr[k]];
            end
        end
    end

    task automatic chk(input string nm, input logic [511:0] act, input logic [511:0] exp);
        n_chk++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", nm, act, exp);
        end
    endtask

    // Reference model state
    int            m_rr;
    logic [N-1:0]  m_rv;
    logic [N-1:0][31:0] m_rd;
    logic [31:0]   model_mem [0:(1<<AW)-1];
    logic [N-1:0]  last_gnt;

    task automatic do_reset();
        @(negedge clk);
        rst = 1'b1; req = '0; we = '0;
        @(negedge clk);
        @(negedge clk);
        rst = 1'b0;
        m_rr = 0; m_rv = '0; m_rd = '0;
    endtask

    // One cycle against the model; called at a negedge with inputs set, returns at the next negedge.
    task automatic model_cycle(input string tag);
        logic [N-1:0] eg;
        logic [P-1:0] emr, emw;
        logic [P-1:0][AW-1:0] ema;
        logic [P-1:0][31:0] emd;
        int nsel, last;
        int wa[$];
        logic dup;
        eg = '0; emr = '0; emw = '0; ema = '0; emd = '0; nsel = 0; last = -1;
        for (int j = 0; j < N; j++) begin
            int i;
            i = (m_rr + j) % N;
            if (req[i] && nsel < P) begin
                dup = 1'b0;
                if (we[i]) foreach (wa[w]) if (wa[w] == int'(addr[i])) dup = 1'b1;
                if (!dup) begin
                    eg[i] = 1'b1; emr[nsel] = 1'b1; emw[nsel] = we[i];
                    ema[nsel] = addr[i]; emd[nsel] = wdata[i];
                    nsel++; last = i;
                    if (we[i]) wa.push_back(int'(addr[i]));
                end
            end
        end
        #2;
        chk({tag, " gnt"}, 512'(gnt), 512'(eg));
        chk({tag, " stall"}, 512'(stall), 512'(|(req & ~eg)));
        chk({tag, " mem_req"}, 512'(mem_req), 512'(emr));
        chk({tag, " mem_we"}, 512'(mem_we), 512'(emw));
        chk({tag, " mem_addr"}, 512'(mem_addr), 512'(ema));
        chk({tag, " mem_wdata"}, 512'(mem_wdata), 512'(emd));
        chk({tag, " rvalid"}, 512'(rvalid), 512'(m_rv));
        chk({tag, " rdata"}, 512'(rdata), 512'(m_rd));
        m_rv = '0; m_rd = '0;
        for (int i = 0; i < N; i++)
            if (eg[i] && !we[i]) begin m_rv[i] = 1'b1; m_rd[i] = model_mem[addr[i]]; end
        for (int i = 0; i < N; i++)
            if (eg[i] && we[i]) model_mem[addr[i]] = wdata[i];
        if (last >= 0) m_rr = (last + 1) % N;
        last_gnt = eg;
        @(negedge clk);
    endtask

    typedef struct {
        logic [N-1:0] req;
        logic [N-1:0] we;
        bit           same;
        logic [N-1:0] gnt;
        bit           stall;
    } vec_t;
    vec_t tbl [12];

    initial begin
        logic [N-1:0] pend;

        // Reset state with every PE requesting
        req = '1; we = '0;
        repeat (2) @(negedge clk);
        #2;
        chk("rst gnt", 512'(gnt), 512'(0));
        chk("rst mem_req", 512'(mem_req), 512'(0));
        chk("rst mem_we", 512'(mem_we), 512'(0));
        chk("rst stall", 512'(stall), 512'(0));
        chk("rst rvalid", 512'(rvalid), 512'(0));
        chk("rst rdata", 512'(rdata), 512'(0));

        // Vector table, consecutive from rr_ptr=0 (same=1: all PEs address 0x100)
        tbl[0]  = '{16'h0000, 16'h0000, 1'b0, 16'h0000, 1'b0};
        tbl[1]  = '{16'h0020, 16'h0000, 1'b0, 16'h0020, 1'b0};
        tbl[2]  = '{16'h0021, 16'h0000, 1'b0, 16'h0021, 1'b0};
        tbl[3]  = '{16'h8041, 16'h0000, 1'b0, 16'h8040, 1'b1};
        tbl[4]  = '{16'h0001, 16'h0000, 1'b0, 16'h0001, 1'b0};
        tbl[5]  = '{16'h0204, 16'h0204, 1'b1, 16'h0004, 1'b1};
        tbl[6]  = '{16'h0200, 16'h0200, 1'b1, 16'h0200, 1'b0};
        tbl[7]  = '{16'h0018, 16'h0008, 1'b1, 16'h0018, 1'b0};
        tbl[8]  = '{16'hFFFF, 16'h0000, 1'b0, 16'h0060, 1'b1};
        tbl[9]  = '{16'hFFFF, 16'hFFFF, 1'b1, 16'h0080, 1'b1};
        tbl[10] = '{16'hFFFF, 16'hFFFF, 1'b0, 16'h0300, 1'b1};
        tbl[11] = '{16'h0400, 16'h0000, 1'b0, 16'h0400, 1'b0};
        do_reset();
        for (int t = 0; t < 12; t++) begin
            req = tbl[t].req; we = tbl[t].we;
            for (int i = 0; i < N; i++) begin
                addr[i] = tbl[t].same ? 12'h100 : 12'(i);
                wdata[i] = 32'(i);
            end
            #2;
            chk($sformatf("tbl%0d gnt", t), 512'(gnt), 512'(tbl[t].gnt));
            chk($sformatf("tbl%0d stall", t), 512'(stall), 512'(tbl[t].stall));
            @(negedge clk);
        end

        // Single read returning 0xDEADBEEF
        do_reset();
        req = 16'h0001; we = 16'h0001; addr[0] = 12'h010; wdata[0] = 32'hDEADBEEF;
        @(negedge clk);
        do_reset();
        req = 16'h0020; we = '0; addr[5] = 12'h010;
        #2;
        chk("rd gnt", 512'(gnt), 512'(16'h0020));
        chk("rd port0", 512'({mem_req, mem_we}), 512'(4'b0100));
        chk("rd addr", 512'(mem_addr[0]), 512'(12'h010));
        @(negedge clk);
        req = '0;
        #2;
        chk("rd rvalid", 512'(rvalid), 512'(16'h0020));
        chk("rd rdata", 512'(rdata[5]), 512'(32'hDEADBEEF));
        @(negedge clk);
        #2;
        chk("rd rvalid one-shot", 512'(rvalid), 512'(0));
        @(negedge clk);

        // All 16 PEs hold reads from rr_ptr=0
        do_reset();
        pend = '1; we = '0;
        for (int i = 0; i < N; i++) addr[i] = 12'(i);
        for (int c = 0; c < 9; c++) begin
            req = pend;
            #2;
            if (c < 8) begin
                chk($sformatf("all c%0d gnt", c), 512'(gnt), 512'(16'h3 << (2*c)));
                chk($sformatf("all c%0d stall", c), 512'(stall), 512'(c < 7));
            end
            if (c > 0) chk($sformatf("all c%0d rvalid", c), 512'(rvalid), 512'(16'h3 << (2*(c-1))));
            if (c < 8) pend = pend & ~(16'h3 << (2*c));
            @(negedge clk);
        end
`ifdef DATAMEM_ARB_PERF_EN
        chk("stall_cnt", 512'(stall_cnt), 512'(7));
`endif

        // Same-address write conflict
        do_reset();
        req = 16'h0204; we = 16'h0204; addr[2] = 12'h100; addr[9] = 12'h100;
        #2;
        chk("wc c0 gnt", 512'(gnt), 512'(16'h0004));
        chk("wc c0 stall", 512'(stall), 512'(1));
        @(negedge clk);
        req = 16'h0200;
        #2;
        chk("wc c1 gnt", 512'(gnt), 512'(16'h0200));
        chk("wc c1 stall", 512'(stall), 512'(0));
        @(negedge clk);

        // Read and write to the same address in one cycle
        do_reset();
        req = 16'h0001; we = 16'h0001; addr[0] = 12'h020; wdata[0] = 32'h1111_1111;
        @(negedge clk);
        do_reset();
        req = 16'h0018; we = 16'h0008; addr[3] = 12'h020; addr[4] = 12'h020; wdata[3] = 32'h55;
        #2;
        chk("mix gnt", 512'(gnt), 512'(16'h0018));
        chk("mix mem_we", 512'({mem_req, mem_we}), 512'(4'b1101));
        @(negedge clk);
        req = 16'h0010; we = '0;
        #2;
        chk("mix rvalid", 512'(rvalid), 512'(16'h0010));
        chk("mix rdata old", 512'(rdata[4]), 512'(32'h1111_1111));
        @(negedge clk);
        req = '0;
        #2;
        chk("mix readback", 512'(rdata[4]), 512'(32'h55));
        @(negedge clk);

        // Reset mid-read drops the pending return
        do_reset();
        req = 16'h0080; we = '0; addr[7] = 12'h030;
        #2;
        chk("rmr gnt", 512'(gnt), 512'(16'h0080));
        #1 rst = 1'b1;
        #1;
        chk("rmr outs", 512'({gnt, rvalid, mem_req, mem_we, stall}), 512'(0));
        chk("rmr rdata", 512'(rdata), 512'(0));
        @(negedge clk);
        req = '0; rst = 1'b0;
        #2;
        chk("rmr no rvalid", 512'(rvalid), 512'(0));
        @(negedge clk);
        req = '1;
        #2;
        chk("rmr rr0 gnt", 512'(gnt), 512'(16'h0003));
        chk("rmr no rvalid2", 512'(rvalid), 512'(0));
        @(negedge clk);

        // Random traffic against the model; preload addresses 0..7 first
        do_reset();
        pend = 16'h00FF;
        for (int i = 0; i < N; i++) begin
            we[i] = 1'b1; addr[i] = 12'(i % 8); wdata[i] = $urandom;
        end
        for (int c = 0; c < 4; c++) begin
            req = pend;
            model_cycle("pre");
            pend = pend & ~last_gnt;
        end
        pend = '0;
        for (int c = 0; c < 1500; c++) begin
            for (int i = 0; i < N; i++) begin
                if (!pend[i] && $urandom_range(0, 2) == 0) begin
                    pend[i] = 1'b1;
                    we[i] = 1'($urandom_range(0, 1));
                    addr[i] = 12'($urandom_range(0, 7));
                    wdata[i] = $urandom;
                end
            end
            req = pend;
            model_cycle("rnd");
            pend = pend & ~last_gnt;
        end
        req = '0;
        model_cycle("drain");

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

endmodule
